// File: rtl/uart_frame_loader.sv
// UART frame parser: A5 / CMD / LEN / payload / CHK frames are checked, their payload is
// written to the weight or input RAM, and a valid input frame kicks off an inference.
module uart_frame_loader #(
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_done,
   input  logic [7:0]        rx_data,
   output logic              rx_enable,
   input  logic              nn_busy,
   output logic              mem_we,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              nn_start,
   output logic              frame_ok,
   output logic              frame_err,
   output logic [1:0]        err_code
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [31:0] MAX_LEN = 32'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD     = 3'd1,
      S_LEN     = 3'd2,
      S_PAYLOAD = 3'd3,
      S_CHK     = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              done_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        chk_q, chk_d;
   logic              sel_q, sel_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              rx_enable_q;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              nn_start_q, nn_start_d;
   logic              frame_ok_q, frame_ok_d;
   logic              frame_err_q, frame_err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [31:0]       len_ext_s;

   assign len_ext_s = {24'd0, rx_data};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      chk_d       = chk_q;
      sel_d       = sel_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      nn_start_d  = 1'b0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;

      // Inter-byte watchdog only runs while a frame is open.
      if (state_q == S_IDLE || done_q) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      if (done_q) begin
         case (state_q)
            S_IDLE: begin
               if (rx_data == 8'hA5) begin
                  state_d = S_CMD;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CMD: begin
               if (rx_data == 8'h01 && nn_busy) begin
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd0;
                  state_d     = S_IDLE;
               end else if (rx_data == 8'h00 || rx_data == 8'h01) begin
                  chk_d   = rx_data;
                  sel_d   = rx_data[0];
                  state_d = S_LEN;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd1;
                  state_d     = S_IDLE;
               end
            end
            S_LEN: begin
               if (rx_data == 8'h00 || len_ext_s > MAX_LEN) begin
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd1;
                  state_d     = S_IDLE;
               end else begin
                  cnt_d   = CNT_W'(rx_data);
                  addr_d  = '0;
                  chk_d   = chk_q ^ rx_data;
                  state_d = S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = rx_data;
               addr_d      = addr_q + ADDR_W'(1);
               cnt_d       = cnt_q - CNT_W'(1);
               chk_d       = chk_q ^ rx_data;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
            S_CHK: begin
               if (rx_data == chk_q) begin
                  frame_ok_d = 1'b1;
                  nn_start_d = sel_q;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd2;
               end
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
         frame_err_d = 1'b1;
         err_code_d  = 2'd3;
         state_d     = S_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         done_q      <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         chk_q       <= 8'd0;
         sel_q       <= 1'b0;
         tmo_q       <= '0;
         rx_enable_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'd0;
         nn_start_q  <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         done_q      <= rx_done;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         chk_q       <= chk_d;
         sel_q       <= sel_d;
         tmo_q       <= tmo_d;
         rx_enable_q <= !nn_busy;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         nn_start_q  <= nn_start_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign rx_enable = rx_enable_q;
   assign mem_we    = mem_we_q;
   assign mem_sel   = sel_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign nn_start  = nn_start_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: expected RAM writes and frame outcomes are queued
// by the stimulus and popped by a monitor whenever the DUT strobes an output.
module tb_uart_frame_loader;

   localparam int ADDR_W = 8;
   localparam int TMO    = 50;

   logic              clk = 1'b0;
   logic              rst;
   logic              rx_done;
   logic [7:0]        rx_data;
   logic              rx_enable;
   logic              nn_busy;
   logic              mem_we;
   logic              mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              nn_start;
   logic              frame_ok;
   logic              frame_err;
   logic [1:0]        err_code;

   int checks = 0;
   int passes = 0;

   logic [16:0] wr_q[$];   // {sel, addr, data}
   logic [4:0]  ev_q[$];   // {ok, start, err, code}

   uart_frame_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
      .rx_enable(rx_enable), .nn_busy(nn_busy), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .nn_start(nn_start),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            if (wr_q.size() == 0) check("unexpected_write", {15'd0, mem_sel, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            else check("write", {15'd0, mem_sel, mem_addr, mem_wdata}, {15'd0, wr_q.pop_front()});
         end
         if (frame_ok || frame_err || nn_start) begin
            if (ev_q.size() == 0) begin
               check("unexpected_event", {27'd0, frame_ok, nn_start, frame_err, err_code}, 32'hFFFF_FFFF);
            end else begin
               logic [4:0] e;
               e = ev_q.pop_front();
               if (e[2]) check("event_err", {27'd0, frame_ok, nn_start, frame_err, err_code}, {27'd0, e});
               else      check("event_ok", {29'd0, frame_ok, nn_start, frame_err}, {29'd0, e[4:2]});
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_done = 1'b1;
      rx_data = 8'($urandom);
      @(posedge clk); #1;
      rx_done = 1'b0;
      rx_data = b;
      repeat ($urandom_range(0, 3)) @(posedge clk);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((wr_q.size() != 0 || ev_q.size() != 0) && n < 2000) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      check({name, "_drained"}, {16'd0, 8'(wr_q.size()), 8'(ev_q.size())}, 32'd0);
      wr_q.delete();
      ev_q.delete();
   endtask

   // Reference: a well-formed frame writes every payload byte at its index, then either
   // accepts (start only for input RAM) or reports a checksum error.
   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] pl[$], input bit corrupt);
      logic [7:0] x;
      x = cmd ^ 8'(pl.size());
      foreach (pl[i]) begin
         x ^= pl[i];
         wr_q.push_back({cmd[0], 8'(i), pl[i]});
      end
      if (corrupt) begin
         x ^= 8'(1 << $urandom_range(0, 7));
         ev_q.push_back({1'b0, 1'b0, 1'b1, 2'd2});
      end else begin
         ev_q.push_back({1'b1, cmd[0], 1'b0, 2'd0});
      end
      send_byte(8'hA5);
      send_byte(cmd);
      send_byte(8'(pl.size()));
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(x);
   endtask

   initial begin
      logic [7:0] pl[$];
      rst = 1'b1; rx_done = 1'b0; rx_data = 8'd0; nn_busy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {20'd0, rx_enable, mem_we, mem_sel, mem_addr != 8'd0, mem_wdata != 8'd0,
            nn_start, frame_ok, frame_err, 2'd0, err_code}, 32'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rx_enable_idle", {31'd0, rx_enable}, 32'd1);

      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h00, pl, 1'b0);
      wait_drain("weight_frame");

      pl = '{8'h0F, 8'hF0};
      send_frame(8'h01, pl, 1'b0);
      wait_drain("input_frame");

      wr_q.push_back({1'b0, 8'd0, 8'h01});
      wr_q.push_back({1'b0, 8'd1, 8'h02});
      ev_q.push_back({1'b0, 1'b0, 1'b1, 2'd2});
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
      wait_drain("bad_chk");
      check("err_code_chk", {30'd0, err_code}, 32'd2);

      wr_q.push_back({1'b0, 8'd0, 8'hAA});
      ev_q.push_back({1'b0, 1'b0, 1'b1, 2'd3});
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05); send_byte(8'hAA);
      repeat (TMO + 10) @(posedge clk);
      wait_drain("timeout");
      pl = '{8'h7E};
      send_frame(8'h00, pl, 1'b0);
      wait_drain("after_timeout");
      check("err_code_sticky", {30'd0, err_code}, 32'd3);

      ev_q.push_back({1'b0, 1'b0, 1'b1, 2'd1});
      send_byte(8'h55); send_byte(8'hA5); send_byte(8'h07);
      wait_drain("bad_cmd");
      check("err_code_cmd", {30'd0, err_code}, 32'd1);
      ev_q.push_back({1'b0, 1'b0, 1'b1, 2'd1});
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      wait_drain("len_zero");

      for (int f = 0; f < 12; f++) begin
         pl.delete();
         repeat ($urandom_range(1, 6)) pl.push_back(8'($urandom));
         send_frame(8'($urandom_range(0, 1)), pl, $urandom_range(0, 3) == 0);
         wait_drain("random_frame");
      end

      pl.delete();
      for (int i = 0; i < 255; i++) pl.push_back(8'($urandom));
      send_frame(8'h01, pl, 1'b0);
      wait_drain("max_len");

      nn_busy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rx_enable_busy", {31'd0, rx_enable}, 32'd0);
      ev_q.push_back({1'b0, 1'b0, 1'b1, 2'd0});
      send_byte(8'hA5); send_byte(8'h01);
      wait_drain("busy_guard");
      check("err_code_busy", {30'd0, err_code}, 32'd0);
      nn_busy = 1'b0;

      wr_q.push_back({1'b0, 8'd0, 8'h11});
      wr_q.push_back({1'b0, 8'd1, 8'h22});
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
      send_byte(8'h11); send_byte(8'h22);
      wait_drain("pre_reset");
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("midframe_reset", {23'd0, rx_enable, mem_we, mem_sel, nn_start, frame_ok, frame_err,
            2'd0, err_code}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      pl = '{8'h5A, 8'hC3};
      send_frame(8'h01, pl, 1'b0);
      wait_drain("after_reset");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
